// File: rtl/obj_bg_pixel_mixer.sv
// OBJ/BG pixel mixer: picks the top two visible layers, fetches both colours from palette RAM and
// applies the GBA colour special effects, producing one BGR555 pixel every four clocks.
module obj_bg_pixel_mixer #(
  parameter int unsigned LATENCY_CHECK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixel_start,
  input  logic [19:0] bg0_packet,
  input  logic [19:0] bg1_packet,
  input  logic [19:0] bg2_packet,
  input  logic [19:0] bg3_packet,
  input  logic [19:0] obj_packet,
  input  logic [15:0] dispcnt,
  input  logic [15:0] bldcnt,
  input  logic [15:0] bldalpha,
  input  logic [15:0] bldy,
  output logic [8:0]  pal_addr,
  input  logic [15:0] pal_data,
  output logic [14:0] color_out,
  output logic        color_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StBlend} state_e;
  typedef enum logic [1:0] {FxNone, FxAlpha, FxBright, FxDark} fx_e;

  // Layer select codes, in tie-break order: OBJ first, then BG0..BG3, backdrop last.
  localparam logic [2:0] SelObj = 3'd0;
  localparam logic [2:0] SelBd  = 3'd5;

  function automatic logic [2:0] tgt_bit(input logic [2:0] sel);
    case (sel)
      3'd0:                   return 3'd4;
      3'd1, 3'd2, 3'd3, 3'd4: return sel - 3'd1;
      default:                return 3'd5;
    endcase
  endfunction

  function automatic logic [4:0] clamp16(input logic [4:0] v);
    return (v > 5'd16) ? 5'd16 : v;
  endfunction

  function automatic logic [4:0] alpha_ch(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] ea, input logic [4:0] eb);
    logic [10:0] s;
    s = 11'(a) * 11'(ea) + 11'(b) * 11'(eb);
    s = s >> 4;
    return (s > 11'd31) ? 5'd31 : s[4:0];
  endfunction

  function automatic logic [4:0] bright_ch(input logic [4:0] a, input logic [4:0] ey);
    logic [9:0] p;
    p = 10'(5'd31 - a) * 10'(ey);
    return 5'(6'(a) + p[9:4]);
  endfunction

  function automatic logic [4:0] dark_ch(input logic [4:0] a, input logic [4:0] ey);
    logic [9:0] p;
    p = 10'(a) * 10'(ey);
    return 5'(6'(a) - p[9:4]);
  endfunction

  state_e      state_q;
  fx_e         fx_d, fx_q;
  logic [8:0]  sec_addr_q;
  logic [4:0]  eva_q, evb_q, evy_q;
  logic [14:0] c1_q;

  logic [19:0] pkt [5];
  logic [4:0]  layer_en;
  logic [2:0]  top_sel, sec_sel, top_pri, sec_pri;
  logic [8:0]  top_addr, sec_addr;
  logic        obj_semi, top_in_a, sec_in_b;
  logic [14:0] mix;

  assign pkt[0]   = obj_packet;
  assign pkt[1]   = bg0_packet;
  assign pkt[2]   = bg1_packet;
  assign pkt[3]   = bg2_packet;
  assign pkt[4]   = bg3_packet;
  assign layer_en = {dispcnt[11:8], dispcnt[12]};

  // Scanning in tie-break order with strict compares keeps the earlier layer on equal priority.
  always_comb begin
    top_sel  = SelBd;
    sec_sel  = SelBd;
    top_pri  = 3'd4;
    sec_pri  = 3'd4;
    top_addr = 9'h000;
    sec_addr = 9'h000;
    for (int r = 0; r < 5; r++) begin
      if (layer_en[r] && (pkt[r][7:0] != 8'h00)) begin
        if ({1'b0, pkt[r][19:18]} < top_pri) begin
          sec_sel  = top_sel;
          sec_pri  = top_pri;
          sec_addr = top_addr;
          top_sel  = 3'(r);
          top_pri  = {1'b0, pkt[r][19:18]};
          top_addr = {pkt[r][8], pkt[r][7:0]};
        end else if ({1'b0, pkt[r][19:18]} < sec_pri) begin
          sec_sel  = 3'(r);
          sec_pri  = {1'b0, pkt[r][19:18]};
          sec_addr = {pkt[r][8], pkt[r][7:0]};
        end
      end
    end
  end

  assign obj_semi = (top_sel == SelObj) && (obj_packet[14:13] == 2'b01);
  assign top_in_a = bldcnt[5:0][tgt_bit(top_sel)];
  assign sec_in_b = bldcnt[13:8][tgt_bit(sec_sel)];

  always_comb begin
    fx_d = FxNone;
    if (obj_semi && sec_in_b) begin
      fx_d = FxAlpha;
    end else if (top_in_a) begin
      case (bldcnt[7:6])
        2'b01:   fx_d = sec_in_b ? FxAlpha : FxNone;
        2'b10:   fx_d = FxBright;
        2'b11:   fx_d = FxDark;
        default: fx_d = FxNone;
      endcase
    end
  end

  // c2 is consumed straight off the palette port in the BLEND cycle.
  always_comb begin
    mix = c1_q;
    for (int i = 0; i < 3; i++) begin
      case (fx_q)
        FxAlpha:  mix[5*i +: 5] = alpha_ch(c1_q[5*i +: 5], pal_data[5*i +: 5], eva_q, evb_q);
        FxBright: mix[5*i +: 5] = bright_ch(c1_q[5*i +: 5], evy_q);
        FxDark:   mix[5*i +: 5] = dark_ch(c1_q[5*i +: 5], evy_q);
        default:  mix[5*i +: 5] = c1_q[5*i +: 5];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      fx_q        <= FxNone;
      sec_addr_q  <= 9'h000;
      eva_q       <= 5'd0;
      evb_q       <= 5'd0;
      evy_q       <= 5'd0;
      c1_q        <= 15'h0000;
      pal_addr    <= 9'h000;
      color_out   <= 15'h0000;
      color_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      if ((LATENCY_CHECK != 0) && pixel_start && (state_q != StIdle)) begin
        overrun <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pixel_start) begin
            fx_q       <= fx_d;
            sec_addr_q <= sec_addr;
            eva_q      <= clamp16(bldalpha[4:0]);
            evb_q      <= clamp16(bldalpha[12:8]);
            evy_q      <= clamp16(bldy[4:0]);
            pal_addr   <= top_addr;
            state_q    <= StRd1;
          end
        end
        StRd1: begin
          pal_addr <= sec_addr_q;
          state_q  <= StRd2;
        end
        StRd2: begin
          c1_q    <= pal_data[14:0];
          state_q <= StBlend;
        end
        StBlend: begin
          color_out   <= mix;
          color_valid <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  logic unused_bits;
  assign unused_bits = ^{bg0_packet[17:9], bg1_packet[17:9], bg2_packet[17:9], bg3_packet[17:9],
                         obj_packet[17:9], dispcnt[15:13], dispcnt[7:0], bldcnt[15:14],
                         bldalpha[15:13], bldalpha[7:5], bldy[15:5], pal_data[15]};

endmodule

// File: tb/tb_obj_bg_pixel_mixer.sv
// Bench for obj_bg_pixel_mixer: directed plus randomized pixels against a sorting-based model,
// with a synchronous palette RAM model behind the read port.
module tb_obj_bg_pixel_mixer;

  logic        clock = 1'b0;
  logic        reset;
  logic        pixel_start;
  logic [19:0] pk [0:4];
  logic [15:0] dispcnt, bldcnt, bldalpha, bldy;
  logic [8:0]  pal_addr;
  logic [15:0] pal_data;
  logic [14:0] color_out;
  logic        color_valid, busy, overrun;

  logic [15:0] pal_mem [0:511];

  int n_vec  = 0;
  int n_fail = 0;

  logic [8:0]  exp_a1, exp_a2;
  logic [14:0] exp_col;
  logic [14:0] obs_color;
  logic [8:0]  obs_a1, obs_a2;

  always #5 clock = ~clock;

  always @(posedge clock) pal_data <= pal_mem[pal_addr];

  obj_bg_pixel_mixer #(.LATENCY_CHECK(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_start (pixel_start),
    .bg0_packet  (pk[1]),
    .bg1_packet  (pk[2]),
    .bg2_packet  (pk[3]),
    .bg3_packet  (pk[4]),
    .obj_packet  (pk[0]),
    .dispcnt     (dispcnt),
    .bldcnt      (bldcnt),
    .bldalpha    (bldalpha),
    .bldy        (bldy),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .color_out   (color_out),
    .color_valid (color_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Blend-target bit position for layer code (0=OBJ, 1..4=BG0..3, 5=backdrop).
  function automatic int tbit(input int s);
    if (s == 0) return 4;
    if (s == 5) return 5;
    return s - 1;
  endfunction

  function automatic int min16(input int v);
    return (v > 16) ? 16 : v;
  endfunction

  function automatic int ch_fx(input int eff, input int a, input int b, input int eva,
                               input int evb, input int evy);
    int r;
    case (eff)
      1: begin
        r = (a * eva + b * evb) / 16;
        if (r > 31) r = 31;
      end
      2: r = a + ((31 - a) * evy) / 16;
      3: r = a - (a * evy) / 16;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] layer_addr(input int s);
    if (s == 5) return 9'h000;
    return {pk[s][8], pk[s][7:0]};
  endfunction

  // Candidates get a key pri*8+order; sorting the keys yields top and second directly.
  function automatic void predict();
    int q[$];
    int ts, ss, eff, eva, evb, evy;
    bit en, semi, ta, sb;
    logic [14:0] c1, c2;
    for (int r = 0; r < 5; r++) begin
      en = (r == 0) ? dispcnt[12] : dispcnt[7 + r];
      if (en && pk[r][7:0] != 8'h00) q.push_back(int'(pk[r][19:18]) * 8 + r);
    end
    q.sort();
    ts = (q.size() > 0) ? q[0] % 8 : 5;
    ss = (q.size() > 1) ? q[1] % 8 : 5;
    exp_a1 = layer_addr(ts);
    exp_a2 = layer_addr(ss);
    eva = min16(int'(bldalpha[4:0]));
    evb = min16(int'(bldalpha[12:8]));
    evy = min16(int'(bldy[4:0]));
    semi = (ts == 0) && (pk[0][14:13] == 2'b01);
    ta = bldcnt[tbit(ts)];
    sb = bldcnt[8 + tbit(ss)];
    eff = 0;
    if (semi && sb) eff = 1;
    else if (ta) begin
      case (bldcnt[7:6])
        2'b01: eff = sb ? 1 : 0;
        2'b10: eff = 2;
        2'b11: eff = 3;
        default: eff = 0;
      endcase
    end
    c1 = pal_mem[exp_a1][14:0];
    c2 = pal_mem[exp_a2][14:0];
    exp_col = '0;
    for (int k = 0; k < 3; k++) begin
      exp_col = exp_col | 15'(ch_fx(eff, (int'(c1) >> (5 * k)) & 31, (int'(c2) >> (5 * k)) & 31,
                                     eva, evb, evy) << (5 * k));
    end
  endfunction

  function automatic logic [19:0] rnd_pkt(input int id);
    logic [7:0] idx;
    idx = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return {2'($urandom_range(0, 3)), 3'(id), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), idx};
  endfunction

  task automatic clear_pk();
    for (int r = 0; r < 5; r++) pk[r] = 20'h0;
  endtask

  // Called and returns at a negedge; runs one full pixel and checks every stage.
  task automatic run_pixel(input string tag, input bit scramble);
    predict();
    pixel_start = 1'b1;
    @(negedge clock);
    pixel_start = 1'b0;
    if (scramble) begin
      for (int r = 0; r < 5; r++) pk[r] = rnd_pkt((r == 0) ? 5 : r - 1);
      dispcnt  = 16'($urandom);
      bldcnt   = 16'($urandom);
      bldalpha = 16'($urandom);
      bldy     = 16'($urandom);
    end
    obs_a1 = pal_addr;
    chk({tag, ".addr1"}, 32'(pal_addr), 32'(exp_a1));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".cv1"}, 32'(color_valid), 32'd0);
    @(negedge clock);
    obs_a2 = pal_addr;
    chk({tag, ".addr2"}, 32'(pal_addr), 32'(exp_a2));
    chk({tag, ".cv2"}, 32'(color_valid), 32'd0);
    @(negedge clock);
    chk({tag, ".cv3"}, 32'(color_valid), 32'd0);
    @(negedge clock);
    obs_color = color_out;
    chk({tag, ".cv4"}, 32'(color_valid), 32'd1);
    chk({tag, ".color"}, 32'(color_out), 32'(exp_col));
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    pixel_start = 1'b0;
    clear_pk();
    dispcnt = 16'h1F00;
    bldcnt = 16'h0;
    bldalpha = 16'h0;
    bldy = 16'h0;
    for (int i = 0; i < 512; i++) pal_mem[i] = 16'($urandom);
    pal_mem[9'h000] = 16'h7C1F;
    pal_mem[9'h050] = 16'h001F;
    pal_mem[9'h051] = 16'h7C00;
    pal_mem[9'h120] = 16'h7FFF;
    pal_mem[9'h030] = 16'h7FFF;
    pal_mem[9'h040] = 16'h8000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.pal_addr", 32'(pal_addr), 32'd0);
    chk("rst.color_out", 32'(color_out), 32'd0);
    chk("rst.color_valid", 32'(color_valid), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_pixel("backdrop", 1'b0);
    chk("backdrop.const", 32'(obs_color), 32'h7C1F);

    dispcnt = 16'h1400;
    pk[0] = {2'd1, 3'd5, 2'b00, 4'h0, 1'b1, 8'h12};
    pk[3] = {2'd1, 3'd2, 2'b00, 4'h0, 1'b0, 8'h05};
    run_pixel("tie", 1'b0);
    chk("tie.top", 32'(obs_a1), 32'h112);
    chk("tie.second", 32'(obs_a2), 32'h005);
    chk("tie.color", 32'(obs_color), 32'(pal_mem[9'h112][14:0]));

    clear_pk();
    dispcnt = 16'h0300;
    pk[1] = {2'd0, 3'd0, 2'b00, 4'h0, 1'b0, 8'h50};
    pk[2] = {2'd1, 3'd1, 2'b00, 4'h0, 1'b0, 8'h51};
    bldcnt = 16'h0241;
    bldalpha = 16'h0808;
    run_pixel("alpha", 1'b0);
    chk("alpha.const", 32'(obs_color), 32'h3C0F);

    clear_pk();
    dispcnt = 16'h1100;
    pk[0] = {2'd0, 3'd5, 2'b01, 4'h0, 1'b1, 8'h20};
    pk[1] = {2'd1, 3'd0, 2'b00, 4'h0, 1'b0, 8'h30};
    bldcnt = 16'h0100;
    bldalpha = 16'h1010;
    run_pixel("semi", 1'b0);
    chk("semi.sat", 32'(obs_color), 32'h7FFF);

    clear_pk();
    dispcnt = 16'h0100;
    pk[1] = {2'd0, 3'd0, 2'b00, 4'h0, 1'b0, 8'h40};
    bldcnt = 16'h0081;
    bldy = 16'h0010;
    run_pixel("bright16", 1'b0);
    chk("bright16.const", 32'(obs_color), 32'h7FFF);
    bldy = 16'h001F;
    run_pixel("bright31", 1'b0);
    chk("bright31.const", 32'(obs_color), 32'h7FFF);

    for (int i = 0; i < 200; i++) begin
      for (int r = 0; r < 5; r++) pk[r] = rnd_pkt((r == 0) ? 5 : r - 1);
      dispcnt  = 16'($urandom);
      bldcnt   = 16'($urandom);
      bldalpha = 16'($urandom);
      bldy     = 16'($urandom);
      run_pixel("rand", 1'b1);
    end

    // Second pulse two cycles in lands in RD2 and must be dropped.
    cnt = 0;
    pixel_start = 1'b1;
    @(negedge clock);
    pixel_start = 1'b0;
    cnt += int'(color_valid);
    @(negedge clock);
    cnt += int'(color_valid);
    pixel_start = 1'b1;
    @(negedge clock);
    pixel_start = 1'b0;
    cnt += int'(color_valid);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      cnt += int'(color_valid);
    end
    chk("ovr.valid_count", 32'(cnt), 32'd1);
    chk("ovr.flag", 32'(overrun), 32'd1);
    chk("ovr.idle", 32'(busy), 32'd0);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst2.overrun", 32'(overrun), 32'd0);
    pixel_start = 1'b1;
    @(negedge clock);
    pixel_start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst.cv", 32'(color_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.overrun", 32'(overrun), 32'd0);
    chk("midrst.pal_addr", 32'(pal_addr), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      cnt += int'(color_valid);
    end
    chk("midrst.no_valid", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
